// File: rtl/peripheral_spram_ahb3_ctrl.sv
// AHB3-Lite slave bridging to a 1R1W byte-enabled SRAM with 1-cycle registered read.
// Zero-wait reads and writes; one wait state on read-after-write to the same word.
module peripheral_spram_ahb3_ctrl #(
  parameter int unsigned ABITS      = 10,
  parameter int unsigned HADDR_SIZE = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [31:0]           HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [ABITS-1:0]      mem_waddr_o,
  output logic [31:0]           mem_din_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ABITS-1:0]      mem_raddr_o,
  input  logic [31:0]           mem_dout_i
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RAW,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t           state_q, state_d;
  logic             accept, size_err, rd_accept, raw_hit;
  logic [ABITS-1:0] haddr_word, waddr_q, raddr_q;
  logic [BW-1:0]    be_c, be_q;
  logic             hreadyout_q, hresp_q, we_q, rd_q;
  logic             unused_bits;

  // Address-phase decode and next-state selection
  always_comb begin
    haddr_word = HADDR[ABITS+1:2];
    accept     = HSEL & HREADY & HTRANS[1] & hreadyout_q;
    size_err   = (HSIZE > 3'd2);
    rd_accept  = accept & ~HWRITE & ~size_err & ~rst_i;
    raw_hit    = (state_q == ST_WR) && (haddr_word == waddr_q);

    case (HSIZE[1:0])
      2'b00:   be_c = 4'b0001 << HADDR[1:0];
      2'b01:   be_c = 4'b0011 << {HADDR[1], 1'b0};
      default: be_c = 4'b1111;
    endcase

    state_d = ST_IDLE;
    if (accept) begin
      if (size_err)     state_d = ST_ERR1;
      else if (HWRITE)  state_d = ST_WR;
      else if (raw_hit) state_d = ST_RAW;
      else              state_d = ST_RD;
    end else if (state_q == ST_RAW) begin
      state_d = ST_RD;
    end else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end
  end

  // State and registered response/write-port controls
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
      be_q        <= '0;
      waddr_q     <= '0;
      raddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= ~((state_d == ST_RAW) || (state_d == ST_ERR1));
      hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
      we_q        <= (state_d == ST_WR);
      rd_q        <= (state_d == ST_RD);
      if (state_d == ST_WR) begin
        waddr_q <= haddr_word;
        be_q    <= be_c;
      end else begin
        be_q    <= '0;
      end
      if (rd_accept) raddr_q <= haddr_word;
    end
  end

  // Read address bypasses the register so the SRAM sees it in the address phase
  assign mem_raddr_o = rd_accept ? haddr_word : raddr_q;
  assign mem_waddr_o = waddr_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_din_o   = we_q ? HWDATA : DW'(0);
  assign HRDATA      = rd_q ? mem_dout_i : DW'(0);
  assign HREADYOUT   = hreadyout_q;
  assign HRESP       = hresp_q;

  assign unused_bits = ^{HBURST, HPROT, HTRANS[0], HADDR};

endmodule

// File: tb/tb_peripheral_spram_ahb3_ctrl.sv
// Bench for peripheral_spram_ahb3_ctrl: pipelined AHB master, behavioural SRAM,
// and a transaction-level reference of memory contents and expected wait states.
module tb_peripheral_spram_ahb3_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [2:0]  HBURST = '0;
  logic [3:0]  HPROT = '0;
  logic [1:0]  HTRANS = '0;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP;
  logic [9:0]  mem_waddr_o, mem_raddr_o;
  logic [31:0] mem_din_o;
  logic [31:0] mem_dout_i = '0;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;

  int n_cmp = 0;
  int n_err = 0;

  peripheral_spram_ahb3_ctrl #(.ABITS(10), .HADDR_SIZE(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .mem_waddr_o(mem_waddr_o), .mem_din_o(mem_din_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_raddr_o(mem_raddr_o), .mem_dout_i(mem_dout_i)
  );

  always #5 clk_i = ~clk_i;
  assign HREADY = HREADYOUT;

  function automatic logic [31:0] pattern(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural SRAM: registered read of the pre-write contents
  logic [31:0] sram [1024];
  bit          loaded = 1'b0;
  int          rst_we_cnt = 0;
  always @(posedge clk_i) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) sram[i] <= pattern(i);
      loaded <= 1'b1;
    end else if (mem_we_o === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) sram[mem_waddr_o][8*b +: 8] <= mem_din_o[8*b +: 8];
    end
    mem_dout_i <= sram[mem_raddr_o];
    if (rst_i && mem_we_o === 1'b1) rst_we_cnt <= rst_we_cnt + 1;
  end

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          valid;
    bit          acc;
    bit          wr;
    bit          err;
    int          exp_wait;
    logic [9:0]  word;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dphase_t;

  txn_t        q[$];
  logic [31:0] ref_mem [1024];

  function automatic logic [9:0] word_of(input logic [31:0] ad);
    return 10'((ad / 4) % 1024);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] sz, input logic [31:0] ad);
    int unsigned off;
    off = ad % 4;
    if (sz == 3'd0) return 4'(1 << off);
    if (sz == 3'd1) return 4'(3 << ((off / 2) * 2));
    return 4'hF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [1:0] tr, input bit wr,
                      input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
    txn_t t;
    t.sel = sel; t.trans = tr; t.wr = wr; t.size = sz; t.addr = ad; t.wdata = wd;
    q.push_back(t);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hreadyout"}, 32'(HREADYOUT), 32'd1);
    check({tag, "_hresp"},     32'(HRESP), 32'd0);
    check({tag, "_hrdata"},    HRDATA, 32'd0);
    check({tag, "_we"},        32'(mem_we_o), 32'd0);
    check({tag, "_be"},        32'(mem_be_o), 32'd0);
    check({tag, "_waddr"},     32'(mem_waddr_o), 32'd0);
    check({tag, "_raddr"},     32'(mem_raddr_o), 32'd0);
    check({tag, "_din"},       mem_din_o, 32'd0);
  endtask

  // Data-phase checks for one cycle of a pending transfer
  task automatic check_dphase(input dphase_t d, input int w);
    bit exp_rdy;
    exp_rdy = (w >= d.exp_wait);
    check("hreadyout", 32'(HREADYOUT), 32'(exp_rdy));
    check("hresp", 32'(HRESP), 32'(d.err));
    if (d.acc && d.wr && !d.err) begin
      check("we", 32'(mem_we_o), 32'd1);
      check("be", 32'(mem_be_o), 32'(d.be));
      check("waddr", 32'(mem_waddr_o), 32'(d.word));
      check("din", mem_din_o, d.wdata);
    end else begin
      check("we_idle", 32'(mem_we_o), 32'd0);
    end
    if (d.acc && !d.wr && !d.err) begin
      if (!exp_rdy) check("raddr_raw", 32'(mem_raddr_o), 32'(d.word));
      else          check("hrdata", HRDATA, ref_mem[d.word]);
    end
  endtask

  // Pipelined master: drives queued address phases back to back, follows HREADYOUT
  task automatic run_queue();
    txn_t    a;
    dphase_t d, nd;
    int      w;
    logic    rdy;
    d = '{default: 0};
    w = 0;
    while (q.size() != 0 || d.valid) begin
      if (q.size() != 0) a = q[0];
      else begin
        a.sel = 1'b0; a.trans = 2'd0; a.wr = 1'b0; a.size = 3'd2; a.addr = '0; a.wdata = '0;
      end
      HSEL = a.sel; HTRANS = a.trans; HWRITE = a.wr; HSIZE = a.size; HADDR = a.addr;
      HBURST = 3'($urandom); HPROT = 4'($urandom);
      HWDATA = (d.valid && d.wr) ? d.wdata : $urandom;
      @(negedge clk_i);
      rdy = HREADYOUT;
      if (d.valid) check_dphase(d, w);
      if (rdy === 1'b1) begin
        if (d.valid && d.acc && d.wr && !d.err)
          for (int b = 0; b < 4; b++)
            if (d.be[b]) ref_mem[d.word][8*b +: 8] = d.wdata[8*b +: 8];
        nd = '{default: 0};
        if (q.size() != 0) begin
          nd.valid = 1'b1;
          nd.acc   = a.sel && a.trans[1];
          nd.wr    = nd.acc && a.wr;
          nd.err   = nd.acc && (a.size > 3'd2);
          nd.word  = word_of(a.addr);
          nd.be    = exp_be(a.size, a.addr);
          nd.wdata = a.wdata;
          if (nd.err) nd.exp_wait = 1;
          else if (nd.acc && !nd.wr && d.valid && d.acc && d.wr && !d.err && d.word == nd.word)
            nd.exp_wait = 1;
          if (nd.acc && !nd.wr && !nd.err) check("raddr_ap", 32'(mem_raddr_o), 32'(nd.word));
          void'(q.pop_front());
        end
        d = nd;
        w = 0;
      end else begin
        w++;
        if (w > 4) begin
          $display("FAIL stall: HREADYOUT low for %0d cycles, required at most 1", w);
          $fatal(1, "stall timeout");
        end
      end
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = pattern(i);

    // Reset values, with a read presented on the bus while reset is held
    #2 rst_i = 1'b1;
    @(posedge clk_i); #1;
    HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h44;
    @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i); #1;
    HSEL = 1'b0; HTRANS = 2'd0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Word write then read elsewhere
    push(1, 2'd2, 1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    push(1, 2'd2, 0, 3'd2, 32'h20, 32'h0);
    push(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
    // Byte and halfword lanes
    push(1, 2'd2, 1, 3'd0, 32'h13, 32'hAA00_0000);
    push(1, 2'd3, 0, 3'd2, 32'h10, 32'h0);
    push(1, 2'd2, 1, 3'd1, 32'h12, 32'h5566_0000);
    push(1, 2'd3, 0, 3'd2, 32'h10, 32'h0);
    // Read-after-write, same word then neighbouring word
    push(1, 2'd2, 1, 3'd2, 32'h40, 32'h1234_5678);
    push(1, 2'd2, 0, 3'd2, 32'h40, 32'h0);
    push(1, 2'd2, 1, 3'd2, 32'h40, 32'h1234_5678);
    push(1, 2'd2, 0, 3'd2, 32'h44, 32'h0);
    // Oversized transfer, then normal traffic
    push(1, 2'd2, 1, 3'd3, 32'h0C, 32'hFFFF_FFFF);
    push(1, 2'd2, 1, 3'd2, 32'h0C, 32'h0BAD_F00D);
    push(1, 2'd2, 0, 3'd2, 32'h0C, 32'h0);
    // BUSY and unselected must not touch memory
    push(1, 2'd1, 1, 3'd2, 32'h40, 32'hFFFF_0000);
    push(0, 2'd2, 1, 3'd2, 32'h40, 32'h0000_FFFF);
    push(1, 2'd2, 0, 3'd2, 32'h40, 32'h0);
    // Upper address bits alias
    push(1, 2'd2, 1, 3'd2, 32'hABCD_0FFC, 32'h7777_1111);
    push(1, 2'd2, 0, 3'd2, 32'h0000_0FFC, 32'h0);
    run_queue();

    // Reset during a write address phase
    HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h80;
    #2 rst_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("rst_mid");
    @(posedge clk_i); #1;
    HSEL = 1'b0; HTRANS = 2'd0; HWDATA = 32'hCAFE_F00D;
    @(negedge clk_i);
    check("rst_mid_we_hold", 32'(mem_we_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("rst_no_write", 32'(rst_we_cnt), 32'd0);
    push(1, 2'd2, 0, 3'd2, 32'h80, 32'h0);
    push(1, 2'd2, 1, 3'd2, 32'h84, 32'h3141_5926);
    push(1, 2'd2, 0, 3'd2, 32'h84, 32'h0);
    run_queue();

    // Randomized pipelined traffic over a small address pool
    for (int n = 0; n < 400; n++) begin
      int unsigned r, wsel, off;
      logic [2:0]  sz;
      logic [31:0] hi, ad;
      r    = $urandom_range(0, 99);
      wsel = $urandom_range(0, 8);
      if (wsel == 8) wsel = 1023;
      sz   = 3'($urandom_range(0, 2));
      off  = (sz == 3'd0) ? $urandom_range(0, 3) : (sz == 3'd1) ? 2 * $urandom_range(0, 1) : 0;
      hi   = $urandom;
      ad   = (hi & 32'hFFFF_F000) | 32'(wsel << 2) | 32'(off);
      if (r < 42)      push(1, 2'($urandom_range(2, 3)), 1, sz, ad, $urandom);
      else if (r < 84) push(1, 2'($urandom_range(2, 3)), 0, sz, ad, 32'h0);
      else if (r < 88) push(1, 2'd2, 1'($urandom), 3'($urandom_range(3, 7)), ad, $urandom);
      else if (r < 92) push(1, 2'd1, 1'($urandom), sz, ad, $urandom);
      else if (r < 96) push(1, 2'd0, 1'($urandom), sz, ad, $urandom);
      else             push(0, 2'd2, 1'($urandom), sz, ad, $urandom);
    end
    run_queue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/peripheral_spram_ahb3_ctrl.md
PERIPHERAL_SPRAM_AHB3_CTRL -- requirements
Module: peripheral_spram_ahb3_ctrl

Interface
REQ-001 SHALL have parameter ABITS, default 10, memory word-address width.
REQ-002 SHALL have parameter HADDR_SIZE, default 32, AHB address width; data width is fixed at 32 bits and byte enables at 4 bits.
REQ-003 SHALL have ports `clk_i` (input, 1, sole clock, all logic on rising edge) and `rst_i` (input, 1); reset is asynchronous and active-high.
REQ-004 SHALL have AHB slave inputs:
- `HSEL` (1)
- `HADDR` (HADDR_SIZE)
- `HWDATA` (32)
- `HWRITE` (1)
- `HSIZE` (3)
- `HBURST` (3, ignored)
- `HPROT` (4, ignored)
- `HTRANS` (2)
- `HREADY` (1)
REQ-005 SHALL have AHB slave outputs `HRDATA` (32), `HREADYOUT` (1) and `HRESP` (1).
REQ-006 SHALL have memory write-port outputs `mem_waddr_o` (ABITS), `mem_din_o` (32), `mem_we_o` (1) and `mem_be_o` (4).
REQ-007 SHALL have memory read-port output `mem_raddr_o` (ABITS) and input `mem_dout_i` (32); the memory is 1-cycle registered read, 1R1W, byte-enabled.

Function
REQ-008 A transfer SHALL be accepted when HSEL & HREADY & HTRANS[1]=1 (NONSEQ/SEQ); IDLE/BUSY and unselected cycles SHALL get a zero-wait OKAY.
REQ-009 Word address SHALL be HADDR[ABITS+1:2]; upper address bits SHALL be ignored (wrap-around aliasing).
REQ-010 Byte enables SHALL be derived from HSIZE and HADDR[1:0]:
- byte: 0001<<HADDR[1:0]
- halfword: 0011<<{HADDR[1],0}
- word: 1111
REQ-011 An accepted transfer with HSIZE>2 SHALL get a two-cycle ERROR response: HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1; no memory access.
REQ-012 FSM states SHALL be IDLE, WR, RD, RAW, ERR1, ERR2.
- A state is entered from any state whose data phase completes (HREADYOUT=1) on an accepted transfer.
- Otherwise the next state is IDLE.
- RAW is exited to RD with no new acceptance.
- ERR1 is always followed by ERR2.
REQ-013 Write: address phase SHALL register word address and byte enables; in WR, mem_we_o=1, mem_din_o=HWDATA, mem_be_o=registered enables, HREADYOUT=1 (zero wait states).
REQ-014 Read: mem_raddr_o SHALL be driven combinationally from HADDR during an accepted address phase; in RD, HRDATA=mem_dout_i, HREADYOUT=1 (zero wait states).
REQ-015 Read-after-write hazard: a read accepted during WR to the same word address SHALL enter RAW.
- RAW inserts one wait state (HREADYOUT=0) and drives mem_raddr_o from the registered read address.
- RAW then moves to RD returning the new data.
- A read to a different address SHALL NOT stall.
REQ-016 Outside an accepted address phase or RAW, mem_raddr_o SHALL hold its last value; mem_we_o SHALL be 0 in all states except WR.
REQ-017 HRDATA SHALL be full-word in RD (lane selection by master); HRESP SHALL be 0 outside ERR1/ERR2.
REQ-018 Back-to-back pipelined transfers (write->write, read->read, write->read, read->write) SHALL each complete with no idle cycle except REQ-011/REQ-015 cases.

Reset
REQ-019 When rst_i is high, SHALL go to IDLE asynchronously with the following outputs:
- HREADYOUT=1, HRESP=0, HRDATA=0
- mem_we_o=0, mem_be_o=0
- mem_waddr_o=0, mem_raddr_o=0, mem_din_o=0
REQ-020 Reset asserted mid-transfer SHALL abort it with no memory write issued after rst_i rises; the first accepted transfer after release SHALL behave as from IDLE.

Verification
REQ-021 Word write 0xDEADBEEF @0x10, then read @0x20 -> mem_we_o=1 for one cycle with waddr=4, be=1111; read returns stored content with zero wait states.
REQ-022 Byte write 0xAA @0x13 (HSIZE=0) -> mem_be_o=1000, HWDATA[31:24] written.
REQ-022 (cont.) Halfword @0x12 -> be=1100.
REQ-023 Write 0x12345678 @0x40 immediately followed by read @0x40 -> one cycle HREADYOUT=0, then HRDATA=0x12345678.
REQ-023 (cont.) Same with read @0x44 -> no wait state.
REQ-024 Transfer with HSIZE=3 -> HRESP=1/HREADYOUT=0 then HRESP=1/HREADYOUT=1, mem_we_o stays 0.
REQ-024 (cont.) Next NONSEQ is accepted normally.
REQ-025 Assert rst_i during WR address phase -> outputs at reset values, no write reaches memory.
REQ-025 (cont.) HTRANS=BUSY with HSEL=1 -> HREADYOUT=1, HRESP=0, no access.
